writeback_port_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order writeback stage result and a long-latency unit (LLU, e.g. multi-cycle mul/div).
- Buffers LLU results in a small FIFO.
- Pipeline writes have priority. A starvation counter forces an LLU drain by stalling the pipeline.
- Sits between the writeback stage mux output and the register file write port. It also exports a pending-destination mask for decode hazard checks.

---
 rtl/writeback_port_arbiter_pkg.sv | 20 ++
 rtl/writeback_port_arbiter_if.sv | 31 +++
 rtl/writeback_port_arbiter_wb_result_fifo.sv | 74 +++++++
 rtl/writeback_port_arbiter.sv | 123 ++++++++++++
 tb/tb_writeback_port_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_port_arbiter_pkg.sv
// Shared widths, the buffered-result entry type and a register-mask helper
// for the writeback port arbiter.
package writeback_port_arbiter_pkg;

   localparam int unsigned WB_XLEN    = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [WB_XLEN-1:0]    data;
   } wb_entry_t;

   // One-hot register bit; x0 never produces a bit.
   function automatic logic [NUM_REGS-1:0] rd_bit(input logic [REG_ADDR_W-1:0] rd);
      rd_bit = '0;
      if (rd != '0) rd_bit[rd] = 1'b1;
   endfunction

endpackage

// File: rtl/writeback_port_arbiter_if.sv
// Writeback-stage, LLU handshake and register-file write-port signals
// of the writeback port arbiter.
interface writeback_port_arbiter_if
   import writeback_port_arbiter_pkg::*;
#(
   parameter int unsigned XLEN = WB_XLEN
);
   logic                  RegWriteW;
   logic [REG_ADDR_W-1:0] RdW;
   logic [XLEN-1:0]       ResultW;
   logic                  llu_valid;
   logic [REG_ADDR_W-1:0] llu_rd;
   logic [XLEN-1:0]       llu_data;
   logic                  llu_ready;
   logic                  stall_pipe;
   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_waddr;
   logic [XLEN-1:0]       rf_wdata;
   logic [NUM_REGS-1:0]   llu_pending_mask;

   modport slave (
      input  RegWriteW, RdW, ResultW, llu_valid, llu_rd, llu_data,
      output llu_ready, stall_pipe, rf_we, rf_waddr, rf_wdata, llu_pending_mask
   );

   modport master (
      output RegWriteW, RdW, ResultW, llu_valid, llu_rd, llu_data,
      input  llu_ready, stall_pipe, rf_we, rf_waddr, rf_wdata, llu_pending_mask
   );

endinterface

// File: rtl/writeback_port_arbiter_wb_result_fifo.sv
// Small synchronous FIFO of LLU results with a per-entry valid/rd view
// so the owner can derive which registers are still pending.
module wb_result_fifo
   import writeback_port_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned XLEN  = WB_XLEN,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            push,
   input  logic [REG_ADDR_W-1:0]           push_rd,
   input  logic [XLEN-1:0]                 push_data,
   input  logic                            pop,
   output logic [CNT_W-1:0]                count,
   output logic                            full,
   output logic [PTR_W-1:0]                head_ptr,
   output logic [REG_ADDR_W-1:0]           head_rd,
   output logic [XLEN-1:0]                 head_data,
   output logic [DEPTH-1:0]                entry_valid,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd
);

   logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
   logic [XLEN-1:0]       data_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic                  empty;
   logic                  push_ok, pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            rd_q[wr_ptr_q]   <= push_rd;
            data_q[wr_ptr_q] <= push_data;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   always_comb begin
      logic [PTR_W-1:0] off;
      off = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off            = PTR_W'(i) - rd_ptr_q;
         entry_valid[i] = (CNT_W'(off) < count_q);
         entry_rd[i]    = rd_q[i];
      end
   end

   assign count     = count_q;
   assign head_ptr  = rd_ptr_q;
   assign head_rd   = rd_q[rd_ptr_q];
   assign head_data = data_q[rd_ptr_q];

endmodule

// File: rtl/writeback_port_arbiter.sv
// Shares the register-file write port between the writeback stage and buffered
// long-latency-unit results; stalls the pipeline when the LLU head starves.
module writeback_port_arbiter
   import writeback_port_arbiter_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned MAX_WAIT   = 4,
   parameter int unsigned XLEN       = WB_XLEN
) (
   input  logic                      clk,
   input  logic                      rst,
   writeback_port_arbiter_if.slave   wb
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0]                      count;
   logic                                  full;
   logic [PTR_W-1:0]                      head_ptr;
   logic [REG_ADDR_W-1:0]                 head_rd;
   logic [XLEN-1:0]                       head_data;
   logic [FIFO_DEPTH-1:0]                 entry_valid;
   logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;

   logic                  ready, push, pop;
   logic                  pipe_req, head_req, force_drain;
   logic                  stall, we;
   logic [REG_ADDR_W-1:0] waddr;
   logic [XLEN-1:0]       wdata;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic [NUM_REGS-1:0]   mask_q, mask_d;

   // Ready comes from registered state only; gated so it stays low in reset.
   assign ready       = rst && !full;
   assign push        = wb.llu_valid && ready && (wb.llu_rd != '0);
   assign pipe_req    = wb.RegWriteW && (wb.RdW != '0);
   assign head_req    = (count != '0);
   assign force_drain = head_req && (wait_q == WAIT_W'(MAX_WAIT));

   wb_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .XLEN  (XLEN)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_rd     (wb.llu_rd),
      .push_data   (wb.llu_data),
      .pop         (pop),
      .count       (count),
      .full        (full),
      .head_ptr    (head_ptr),
      .head_rd     (head_rd),
      .head_data   (head_data),
      .entry_valid (entry_valid),
      .entry_rd    (entry_rd)
   );

   always_comb begin
      pop   = 1'b0;
      stall = 1'b0;
      we    = 1'b0;
      waddr = head_req ? head_rd : '0;
      wdata = head_req ? head_data : '0;
      if (force_drain) begin
         stall = 1'b1;
         we    = (head_rd != '0);
         pop   = 1'b1;
      end else if (pipe_req) begin
         we    = 1'b1;
         waddr = wb.RdW;
         wdata = wb.ResultW;
      end else if (head_req) begin
         we  = (head_rd != '0);
         pop = 1'b1;
      end
      if (!rst) begin
         we    = 1'b0;
         stall = 1'b0;
         pop   = 1'b0;
      end
   end

   always_comb begin
      wait_d = wait_q;
      if (pop || !head_req) begin
         wait_d = '0;
      end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
         wait_d = wait_q + 1'b1;
      end
   end

   // Mask of the next FIFO contents, so duplicate rds stay set until the last pops.
   always_comb begin
      mask_d = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (entry_valid[i] && !(pop && (PTR_W'(i) == head_ptr))) begin
            mask_d = mask_d | rd_bit(entry_rd[i]);
         end
      end
      if (push) mask_d = mask_d | rd_bit(wb.llu_rd);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_q <= '0;
         mask_q <= '0;
      end else begin
         wait_q <= wait_d;
         mask_q <= mask_d;
      end
   end

   assign wb.llu_ready        = ready;
   assign wb.stall_pipe       = stall;
   assign wb.rf_we            = we;
   assign wb.rf_waddr         = waddr;
   assign wb.rf_wdata         = wdata;
   assign wb.llu_pending_mask = mask_q;

endmodule

// File: tb/tb_writeback_port_arbiter.sv
// Directed and random bench for writeback_port_arbiter against a queue-based
// reference model of the arbitration rules.
module tb_writeback_port_arbiter;
   import writeback_port_arbiter_pkg::*;

   localparam int unsigned DEPTH    = 2;
   localparam int unsigned MAX_WAIT = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   writeback_port_arbiter_if #(.XLEN(32)) wb ();

   writeback_port_arbiter #(
      .FIFO_DEPTH (DEPTH),
      .MAX_WAIT   (MAX_WAIT),
      .XLEN       (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   wb_entry_t  q[$];
   int         w;
   bit         hs;
   logic [4:0] drained[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: compare outputs to the model, then advance the model at the edge.
   task automatic step();
      int          n;
      bit          pipe, hreq, frc, pop;
      logic        e_we, e_stall, e_ready;
      logic [4:0]  e_addr;
      logic [31:0] e_data, e_mask;
      #1;
      n       = q.size();
      e_ready = (n < DEPTH);
      pipe    = wb.RegWriteW && (wb.RdW != 0);
      hreq    = (n != 0);
      frc     = hreq && (w == MAX_WAIT);
      e_mask  = '0;
      foreach (q[i]) e_mask[q[i].rd] = 1'b1;
      e_stall = 1'b0;
      e_we    = 1'b0;
      pop     = 1'b0;
      e_addr  = hreq ? q[0].rd : 5'd0;
      e_data  = hreq ? q[0].data : 32'd0;
      if (frc) begin
         e_stall = 1'b1; e_we = 1'b1; pop = 1'b1;
      end else if (pipe) begin
         e_we = 1'b1; e_addr = wb.RdW; e_data = wb.ResultW;
      end else if (hreq) begin
         e_we = 1'b1; pop = 1'b1;
      end
      check("stall_pipe", 32'(wb.stall_pipe), 32'(e_stall));
      check("rf_we", 32'(wb.rf_we), 32'(e_we));
      check("rf_waddr", 32'(wb.rf_waddr), 32'(e_addr));
      check("rf_wdata", wb.rf_wdata, e_data);
      check("llu_ready", 32'(wb.llu_ready), 32'(e_ready));
      check("pending_mask", wb.llu_pending_mask, e_mask);
      if (wb.stall_pipe) drained.push_back(wb.rf_waddr);
      hs = wb.llu_valid && e_ready;
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (pop || n == 0) w = 0;
      else if (w < MAX_WAIT) w++;
      if (hs && wb.llu_rd != 0) q.push_back('{rd: wb.llu_rd, data: wb.llu_data});
      @(negedge clk);
   endtask

   initial begin
      bit acc;
      n_checks = 0;
      n_fail   = 0;
      w        = 0;
      rst      = 1'b0;
      wb.RegWriteW = 1'b1; wb.RdW = 5'd5; wb.ResultW = 32'h1;
      wb.llu_valid = 1'b1; wb.llu_rd = 5'd6; wb.llu_data = 32'h2;
      #2;
      check("rst_rf_we", 32'(wb.rf_we), 32'd0);
      check("rst_llu_ready", 32'(wb.llu_ready), 32'd0);
      check("rst_stall", 32'(wb.stall_pipe), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      wb.RegWriteW = 1'b0; wb.llu_valid = 1'b0;
      #1;
      check("post_rst_ready", 32'(wb.llu_ready), 32'd1);
      check("post_rst_mask", wb.llu_pending_mask, 32'd0);
      step();

      // Pipeline only
      wb.RegWriteW = 1'b1; wb.RdW = 5'd5; wb.ResultW = 32'h1234;
      #1;
      check("pipe_we", 32'(wb.rf_we), 32'd1);
      check("pipe_waddr", 32'(wb.rf_waddr), 32'd5);
      check("pipe_wdata", wb.rf_wdata, 32'h1234);
      step();
      wb.RdW = 5'd0;
      #1;
      check("pipe_x0_we", 32'(wb.rf_we), 32'd0);
      step();

      // LLU with idle pipeline
      wb.RegWriteW = 1'b0;
      wb.llu_valid = 1'b1; wb.llu_rd = 5'd7; wb.llu_data = 32'hCAFE;
      step();
      wb.llu_valid = 1'b0;
      #1;
      check("llu_mask7_set", 32'(wb.llu_pending_mask[7]), 32'd1);
      check("llu_we", 32'(wb.rf_we), 32'd1);
      check("llu_waddr", 32'(wb.rf_waddr), 32'd7);
      check("llu_wdata", wb.rf_wdata, 32'hCAFE);
      step();
      #1;
      check("llu_mask7_clr", 32'(wb.llu_pending_mask[7]), 32'd0);
      step();

      // Starvation
      wb.llu_valid = 1'b1; wb.llu_rd = 5'd3; wb.llu_data = 32'h33;
      step();
      wb.llu_valid = 1'b0;
      wb.RegWriteW = 1'b1; wb.RdW = 5'd9; wb.ResultW = 32'h99;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("starve_pipe_stall", 32'(wb.stall_pipe), 32'd0);
         check("starve_pipe_waddr", 32'(wb.rf_waddr), 32'd9);
         step();
      end
      #1;
      check("starve_force_stall", 32'(wb.stall_pipe), 32'd1);
      check("starve_force_waddr", 32'(wb.rf_waddr), 32'd3);
      step();
      #1;
      check("starve_regrant_stall", 32'(wb.stall_pipe), 32'd0);
      check("starve_regrant_waddr", 32'(wb.rf_waddr), 32'd9);
      step();

      // Full FIFO with a held third result
      drained.delete();
      wb.RdW = 5'd10; wb.ResultW = 32'hA0;
      wb.llu_valid = 1'b1; wb.llu_rd = 5'd1; wb.llu_data = 32'h11;
      step();
      wb.llu_rd = 5'd2; wb.llu_data = 32'h22;
      step();
      wb.llu_rd = 5'd3; wb.llu_data = 32'h33;
      #1;
      check("full_ready_low", 32'(wb.llu_ready), 32'd0);
      for (int k = 0; k < 25; k++) begin
         #1;
         acc = wb.llu_valid && wb.llu_ready;
         step();
         if (acc) begin
            wb.llu_valid = 1'b0;
            #1;
            check("full_accept_mask3", 32'(wb.llu_pending_mask[3]), 32'd1);
         end
      end
      check("full_drain_count", drained.size(), 32'd3);
      if (drained.size() == 3) begin
         check("full_order0", 32'(drained[0]), 32'd1);
         check("full_order1", 32'(drained[1]), 32'd2);
         check("full_order2", 32'(drained[2]), 32'd3);
      end
      wb.RegWriteW = 1'b0;
      step();

      // Duplicate rd and x0
      wb.llu_valid = 1'b1; wb.llu_rd = 5'd4; wb.llu_data = 32'h41;
      step();
      wb.llu_data = 32'h42;
      step();
      wb.llu_valid = 1'b0;
      #1;
      check("dup_mask4_held", 32'(wb.llu_pending_mask[4]), 32'd1);
      check("dup_second_wdata", wb.rf_wdata, 32'h42);
      step();
      #1;
      check("dup_mask4_clr", 32'(wb.llu_pending_mask[4]), 32'd0);
      wb.llu_valid = 1'b1; wb.llu_rd = 5'd0; wb.llu_data = 32'h55;
      #1;
      check("x0_ready", 32'(wb.llu_ready), 32'd1);
      step();
      wb.llu_valid = 1'b0;
      #1;
      check("x0_no_write", 32'(wb.rf_we), 32'd0);
      check("x0_ready_after", 32'(wb.llu_ready), 32'd1);
      step();

      // Reset in the middle of operation
      wb.RegWriteW = 1'b1; wb.RdW = 5'd11; wb.ResultW = 32'hB0;
      wb.llu_valid = 1'b1; wb.llu_rd = 5'd12; wb.llu_data = 32'hC0;
      step();
      wb.llu_rd = 5'd13; wb.llu_data = 32'hD0;
      step();
      wb.llu_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("midrst_we", 32'(wb.rf_we), 32'd0);
      check("midrst_ready", 32'(wb.llu_ready), 32'd0);
      check("midrst_stall", 32'(wb.stall_pipe), 32'd0);
      check("midrst_mask", wb.llu_pending_mask, 32'd0);
      q.delete();
      w = 0;
      @(negedge clk);
      rst = 1'b1;
      wb.RegWriteW = 1'b0;
      for (int k = 0; k < 3; k++) step();

      // Random traffic honouring the valid/ready hold rule
      for (int k = 0; k < 400; k++) begin
         if (!wb.llu_valid && $urandom_range(0, 2) == 0) begin
            wb.llu_valid = 1'b1;
            wb.llu_rd    = 5'($urandom_range(0, 31));
            wb.llu_data  = $urandom;
         end
         wb.RegWriteW = ($urandom_range(0, 3) != 0);
         wb.RdW       = 5'($urandom_range(0, 31));
         wb.ResultW   = $urandom;
         step();
         if (hs) wb.llu_valid = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
